io_sequencer: RTL and testbench

Sequences the processor's I/O instructions around the single-cycle datapath. When the control unit flags an IN instruction with Halt, this block freezes the PC and register-file write. It waits for a debounced operator confirm press, captures the switch value, then releases the instruction for exactly one cycle. On OUT it latches the register operand into a persistent display register with a one-cycle strobe. It sits between the control unit and the PC and register-file enables, and owns the board switch, button and display interface.

---
 rtl/io_pkg.sv | 17 +
 rtl/io_sequencer_if.sv | 33 +++
 rtl/io_debouncer.sv | 48 ++++
 rtl/io_sequencer.sv | 113 +++++++++++
 tb/tb_io_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the I/O sequencer slice.
package io_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_PRESS = 2'd1,
        CAPTURE    = 2'd2
    } io_state_e;

    // Mem2Reg select value that routes in_data into the register-file write port
    localparam logic [1:0] MEM2REG_IN = 2'b01;

    localparam int unsigned DATA_WIDTH_DEFAULT      = 32;
    localparam int unsigned SW_WIDTH_DEFAULT        = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/io_sequencer_if.sv
// Control-unit and board-side signal bundle of the I/O sequencer.
interface io_sequencer_if
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned SW_WIDTH   = SW_WIDTH_DEFAULT
);

    logic                  op_io;
    logic                  halt;
    logic                  reg_write_i;
    logic [DATA_WIDTH-1:0] out_operand;
    logic [SW_WIDTH-1:0]   switches;
    logic                  confirm_btn;

    logic                  pc_enable;
    logic                  reg_write_o;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] out_reg;
    logic                  out_strobe;
    logic                  waiting_input;

    modport master (
        output op_io, halt, reg_write_i, out_operand, switches, confirm_btn,
        input  pc_enable, reg_write_o, in_data, out_reg, out_strobe, waiting_input
    );

    modport slave (
        input  op_io, halt, reg_write_i, out_operand, switches, confirm_btn,
        output pc_enable, reg_write_o, in_data, out_reg, out_strobe, waiting_input
    );

endinterface

// File: rtl/io_debouncer.sv
// Two-flop synchroniser plus stability counter for the raw confirm button.
module io_debouncer
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_btn_raw,
    output logic o_db_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_db_level = r_level;

endmodule

// File: rtl/io_sequencer.sv
// Stalls the datapath on IN until a debounced confirm press, and latches OUT operands.
module io_sequencer
    import io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic    clock,
    input  logic    reset_n,
    io_sequencer_if.slave bus
);

    io_state_e             r_state;
    io_state_e             w_next;
    logic                  w_db_level;
    logic                  r_armed;
    logic [SW_WIDTH-1:0]   r_sw_sync1;
    logic [SW_WIDTH-1:0]   r_sw_sync2;
    logic [DATA_WIDTH-1:0] r_in_data;
    logic [DATA_WIDTH-1:0] r_out_reg;
    logic                  r_out_strobe;
    logic                  r_waiting;
    logic                  w_pc_enable;
    logic                  w_reg_write;
    logic                  w_capture;
    logic                  w_out_fire;

    io_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_btn_raw  (bus.confirm_btn),
        .o_db_level (w_db_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= bus.switches;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= RUN;
        else          r_state <= w_next;
    end

    // Halt gates PC and write in the same cycle; only an armed press leaves WAIT_PRESS
    always_comb begin
        w_next      = r_state;
        w_pc_enable = 1'b0;
        w_reg_write = 1'b0;
        w_capture   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.halt) begin
                    w_next = WAIT_PRESS;
                end else begin
                    w_pc_enable = 1'b1;
                    w_reg_write = bus.reg_write_i;
                    w_out_fire  = bus.op_io;
                end
            end
            WAIT_PRESS: begin
                if (w_db_level && r_armed) begin
                    w_capture = 1'b1;
                    w_next    = CAPTURE;
                end
            end
            CAPTURE: begin
                w_pc_enable = 1'b1;
                w_reg_write = bus.reg_write_i;
                w_next      = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    // A press held through a capture must be released before it can satisfy another IN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                r_armed <= 1'b1;
        else if (r_state == CAPTURE) r_armed <= 1'b0;
        else if (!w_db_level)        r_armed <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_data    <= '0;
            r_out_reg    <= '0;
            r_out_strobe <= 1'b0;
            r_waiting    <= 1'b0;
        end else begin
            if (w_capture)  r_in_data <= DATA_WIDTH'(r_sw_sync2);
            if (w_out_fire) r_out_reg <= bus.out_operand;
            r_out_strobe <= w_out_fire;
            r_waiting    <= (w_next == WAIT_PRESS);
        end
    end

    assign bus.pc_enable     = w_pc_enable;
    assign bus.reg_write_o   = w_reg_write;
    assign bus.in_data       = r_in_data;
    assign bus.out_reg       = r_out_reg;
    assign bus.out_strobe    = r_out_strobe;
    assign bus.waiting_input = r_waiting;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed and randomized checks of io_sequencer against a cycle-count reference model.
module tb_io_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 16;
    localparam int unsigned DC = 4;
    // Press start to CAPTURE: 2 sync edges + DC debounce edges + 1 FSM edge
    localparam int unsigned PRESS_TO_CAPTURE = DC + 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] m_out_reg = '0;
    logic [DW-1:0] m_in_data = '0;

    always #5 clock = ~clock;

    io_sequencer_if #(.DATA_WIDTH(DW), .SW_WIDTH(SW)) bus ();

    io_sequencer #(
        .DATA_WIDTH      (DW),
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic stall_cycle(input string tag);
        #3;
        chk1({tag, "_wait"}, bus.waiting_input, 1'b1);
        chk1({tag, "_pc"},   bus.pc_enable,     1'b0);
        chk1({tag, "_rw"},   bus.reg_write_o,   1'b0);
        step();
    endtask

    task automatic start_in(input logic [SW-1:0] sw, input logic rw);
        bus.halt        = 1'b1;
        bus.op_io       = 1'b1;
        bus.reg_write_i = rw;
        bus.switches    = sw;
        bus.out_operand = DW'($urandom);
        #3;
        chk1("in_halt_pc",   bus.pc_enable,     1'b0);
        chk1("in_halt_rw",   bus.reg_write_o,   1'b0);
        chk1("in_halt_wait", bus.waiting_input, 1'b0);
        step();
        #3;
        chk1("in_no_strobe",   bus.out_strobe, 1'b0);
        chkw("in_out_reg_kept", bus.out_reg,   m_out_reg);
        #(-0);
    endtask

    task automatic press_and_capture(input logic [SW-1:0] sw, input logic rw);
        bus.confirm_btn = 1'b1;
        for (int n = 0; n < int'(PRESS_TO_CAPTURE); n++) begin
            #3;
            chk1("press_wait", bus.waiting_input, 1'b1);
            chk1("press_pc",   bus.pc_enable,     1'b0);
            chk1("press_rw",   bus.reg_write_o,   1'b0);
            step();
        end
        m_in_data = DW'(sw);
        #3;
        chk1("capture_pc",   bus.pc_enable,     1'b1);
        chk1("capture_wait", bus.waiting_input, 1'b0);
        chk1("capture_rw",   bus.reg_write_o,   rw);
        chkw("capture_data", bus.in_data,       m_in_data);
        step();
        bus.halt  = 1'b0;
        bus.op_io = 1'b0;
        #3;
        chk1("after_in_pc",   bus.pc_enable,     1'b1);
        chk1("after_in_wait", bus.waiting_input, 1'b0);
        chkw("after_in_data", bus.in_data,       m_in_data);
        step();
    endtask

    task automatic release_idle(input int cycles);
        bus.confirm_btn = 1'b0;
        bus.halt        = 1'b0;
        bus.op_io       = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            #3;
            chk1("idle_pc",   bus.pc_enable,     1'b1);
            chk1("idle_wait", bus.waiting_input, 1'b0);
            step();
        end
    endtask

    initial begin
        bus.op_io       = 1'b0;
        bus.halt        = 1'b0;
        bus.reg_write_i = 1'b1;
        bus.out_operand = '0;
        bus.switches    = '0;
        bus.confirm_btn = 1'b0;
        reset_n         = 1'b0;

        // Reset state: RUN decoding on the outputs, registers cleared
        #3;
        chk1("rst_pc",     bus.pc_enable,     1'b1);
        chk1("rst_rw",     bus.reg_write_o,   1'b1);
        chkw("rst_in",     bus.in_data,       '0);
        chkw("rst_out",    bus.out_reg,       '0);
        chk1("rst_strobe", bus.out_strobe,    1'b0);
        chk1("rst_wait",   bus.waiting_input, 1'b0);
        step();
        step();
        reset_n = 1'b1;

        // Non-I/O pass-through
        #3;
        chk1("nop_pc",  bus.pc_enable,   1'b1);
        chk1("nop_rw1", bus.reg_write_o, 1'b1);
        chkw("nop_out", bus.out_reg,     m_out_reg);
        step();
        bus.reg_write_i = 1'b0;
        #3;
        chk1("nop_rw0", bus.reg_write_o, 1'b0);
        step();

        // OUT
        bus.op_io       = 1'b1;
        bus.out_operand = 32'd1234;
        #3;
        chk1("out_pc",      bus.pc_enable,  1'b1);
        chk1("out_pre_stb", bus.out_strobe, 1'b0);
        step();
        bus.op_io = 1'b0;
        m_out_reg = 32'd1234;
        #3;
        chkw("out_reg",    bus.out_reg,    m_out_reg);
        chk1("out_strobe", bus.out_strobe, 1'b1);
        chk1("out_pc2",    bus.pc_enable,  1'b1);
        step();
        #3;
        chk1("out_strobe_end", bus.out_strobe, 1'b0);
        chkw("out_reg_hold",   bus.out_reg,    m_out_reg);
        step();

        // Basic IN with a held press
        start_in(16'hBEEF, 1'b1);
        press_and_capture(16'hBEEF, 1'b1);
        chkw("basic_in_val", bus.in_data, 32'h0000BEEF);

        // Button still held: a second IN must wait for release and a fresh press
        start_in(16'h5A5A, 1'b1);
        for (int n = 0; n < 15; n++) stall_cycle("held");
        bus.confirm_btn = 1'b0;
        for (int n = 0; n < 10; n++) stall_cycle("released");
        press_and_capture(16'h5A5A, 1'b1);
        release_idle(int'(DC) + 5);

        // Glitch shorter than the debounce window
        start_in(16'h0F0F, 1'b0);
        bus.confirm_btn = 1'b1;
        for (int n = 0; n < 3; n++) stall_cycle("glitch_hi");
        bus.confirm_btn = 1'b0;
        for (int n = 0; n < 12; n++) stall_cycle("glitch_lo");
        press_and_capture(16'h0F0F, 1'b0);
        release_idle(int'(DC) + 5);

        // Reset mid-stall
        start_in(16'h1234, 1'b1);
        for (int n = 0; n < 3; n++) stall_cycle("pre_rst");
        reset_n = 1'b0;
        m_in_data = '0;
        #1;
        chk1("mid_rst_wait", bus.waiting_input, 1'b0);
        chk1("mid_rst_pc",   bus.pc_enable,     1'b0);
        chk1("mid_rst_rw",   bus.reg_write_o,   1'b0);
        chkw("mid_rst_in",   bus.in_data,       m_in_data);
        chkw("mid_rst_out",  bus.out_reg,       '0);
        m_out_reg = '0;
        step();
        reset_n = 1'b1;
        #3;
        chk1("post_rst_rw",   bus.reg_write_o,   1'b0);
        chk1("post_rst_wait", bus.waiting_input, 1'b0);
        step();
        press_and_capture(16'h1234, 1'b1);
        release_idle(int'(DC) + 5);

        // Randomized instruction mix
        for (int it = 0; it < 24; it++) begin
            int unsigned kind;
            logic        rw;
            kind = $urandom_range(0, 2);
            rw   = 1'(($urandom) & 1);
            if (kind == 0) begin
                bus.halt        = 1'b0;
                bus.op_io       = 1'b0;
                bus.reg_write_i = rw;
                #3;
                chk1("rnd_nop_pc", bus.pc_enable,   1'b1);
                chk1("rnd_nop_rw", bus.reg_write_o, rw);
                step();
                #3;
                chk1("rnd_nop_stb", bus.out_strobe, 1'b0);
                chkw("rnd_nop_out", bus.out_reg,    m_out_reg);
                step();
            end else if (kind == 1) begin
                logic [DW-1:0] v;
                v = DW'($urandom);
                bus.halt        = 1'b0;
                bus.op_io       = 1'b1;
                bus.reg_write_i = rw;
                bus.out_operand = v;
                #3;
                chk1("rnd_out_pc", bus.pc_enable,   1'b1);
                chk1("rnd_out_rw", bus.reg_write_o, rw);
                step();
                bus.op_io = 1'b0;
                m_out_reg = v;
                #3;
                chkw("rnd_out_reg", bus.out_reg,    m_out_reg);
                chk1("rnd_out_stb", bus.out_strobe, 1'b1);
                step();
            end else begin
                logic [SW-1:0] sw;
                int            dly;
                sw  = SW'($urandom);
                dly = int'($urandom_range(0, 4));
                start_in(sw, rw);
                for (int n = 0; n < dly; n++) stall_cycle("rnd_pre");
                press_and_capture(sw, rw);
                release_idle(int'(DC) + 5);
                chkw("rnd_in_hold", bus.in_data, m_in_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
